stp_frame_ctrl: RTL and testbench

//  Sequencer for the serial-to-parallel shift register (flex_stp_sr) on the password-input path.
//  - Gates the register's shift_enable from a line-sampler bit strobe and counts NUM_BITS bits per word.
//  - Captures each full word and hands it downstream with valid/ready.
//  - Frames a password of frame_len words.
//  - Flags dropped bits (overrun) and illegal frame lengths.

---
 rtl/stp_frame_ctrl.sv | 165 ++++++++++++++++
 tb/tb_stp_frame_ctrl.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stp_frame_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : stp_frame_ctrl
//  Description : Sequencer for the serial-to-parallel shift register on the
//                password-input path. Gates shifting, frames words, hands each
//                word downstream with valid/ready and flags overrun/len errors.
//  Revision    : 1.0 - initial release
// ============================================================================
module stp_frame_ctrl #(
    parameter int NUM_BITS  = 8,
    parameter int MAX_WORDS = 16,
    parameter int LEN_W     = $clog2(MAX_WORDS + 1),
    parameter int IDX_W     = $clog2(MAX_WORDS)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                frame_start,
    input  logic [LEN_W-1:0]    frame_len,
    input  logic                bit_valid,
    input  logic [NUM_BITS-1:0] parallel_in,
    output logic                shift_enable,
    output logic [NUM_BITS-1:0] word_out,
    output logic                word_valid,
    input  logic                word_ready,
    output logic [IDX_W-1:0]    word_idx,
    output logic                word_last,
    output logic                busy,
    output logic                overrun,
    output logic                len_err,
    output logic                frame_done
);

    localparam int                 c_bit_w    = $clog2(NUM_BITS);
    localparam logic [c_bit_w-1:0] c_bit_last = c_bit_w'(NUM_BITS - 1);
    localparam logic [LEN_W-1:0]   c_max_len  = LEN_W'(MAX_WORDS);

    localparam logic [2:0] c_idle    = 3'd0;
    localparam logic [2:0] c_shift   = 3'd1;
    localparam logic [2:0] c_capture = 3'd2;
    localparam logic [2:0] c_hold    = 3'd3;
    localparam logic [2:0] c_done    = 3'd4;

    logic [2:0]          r_state,      w_state_nxt;
    logic [LEN_W-1:0]    r_len,        w_len_nxt;
    logic [c_bit_w-1:0]  r_bit_cnt,    w_bit_cnt_nxt;
    logic [LEN_W-1:0]    r_word_cnt,   w_word_cnt_nxt;
    logic [NUM_BITS-1:0] r_word_out,   w_word_out_nxt;
    logic                r_word_valid, w_word_valid_nxt;
    logic [IDX_W-1:0]    r_word_idx,   w_word_idx_nxt;
    logic                r_word_last,  w_word_last_nxt;
    logic                r_overrun,    w_overrun_nxt;
    logic                r_len_err,    w_len_err_nxt;
    logic                r_frame_done, w_frame_done_nxt;
    logic                w_len_ok;

    assign w_len_ok = (frame_len != '0) && (frame_len <= c_max_len);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= c_idle;
            r_len        <= '0;
            r_bit_cnt    <= '0;
            r_word_cnt   <= '0;
            r_word_out   <= '0;
            r_word_valid <= 1'b0;
            r_word_idx   <= '0;
            r_word_last  <= 1'b0;
            r_overrun    <= 1'b0;
            r_len_err    <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_len        <= w_len_nxt;
            r_bit_cnt    <= w_bit_cnt_nxt;
            r_word_cnt   <= w_word_cnt_nxt;
            r_word_out   <= w_word_out_nxt;
            r_word_valid <= w_word_valid_nxt;
            r_word_idx   <= w_word_idx_nxt;
            r_word_last  <= w_word_last_nxt;
            r_overrun    <= w_overrun_nxt;
            r_len_err    <= w_len_err_nxt;
            r_frame_done <= w_frame_done_nxt;
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_len_nxt        = r_len;
        w_bit_cnt_nxt    = r_bit_cnt;
        w_word_cnt_nxt   = r_word_cnt;
        w_word_out_nxt   = r_word_out;
        w_word_valid_nxt = r_word_valid;
        w_word_idx_nxt   = r_word_idx;
        w_word_last_nxt  = r_word_last;
        w_overrun_nxt    = r_overrun;
        w_len_err_nxt    = 1'b0;
        w_frame_done_nxt = 1'b0;
        case (r_state)
            c_idle: begin
                if (frame_start) begin
                    if (w_len_ok) begin
                        w_len_nxt      = frame_len;
                        w_bit_cnt_nxt  = '0;
                        w_word_cnt_nxt = '0;
                        w_overrun_nxt  = 1'b0;
                        w_state_nxt    = c_shift;
                    end else begin
                        w_len_err_nxt = 1'b1;
                    end
                end
            end
            c_shift: begin
                if (bit_valid) begin
                    // Bit counter parks at its last value; cleared on word handoff.
                    if (r_bit_cnt == c_bit_last) begin
                        w_state_nxt = c_capture;
                    end else begin
                        w_bit_cnt_nxt = r_bit_cnt + c_bit_w'(1);
                    end
                end
            end
            c_capture: begin
                w_overrun_nxt    = r_overrun | bit_valid;
                w_word_out_nxt   = parallel_in;
                w_word_valid_nxt = 1'b1;
                w_word_idx_nxt   = r_word_cnt[IDX_W-1:0];
                w_word_last_nxt  = (r_word_cnt == (r_len - LEN_W'(1)));
                w_state_nxt      = c_hold;
            end
            c_hold: begin
                w_overrun_nxt = r_overrun | bit_valid;
                if (word_ready) begin
                    w_word_valid_nxt = 1'b0;
                    if (r_word_last) begin
                        w_frame_done_nxt = 1'b1;
                        w_state_nxt      = c_done;
                    end else begin
                        w_word_cnt_nxt = r_word_cnt + LEN_W'(1);
                        w_bit_cnt_nxt  = '0;
                        w_state_nxt    = c_shift;
                    end
                end
            end
            c_done: begin
                w_overrun_nxt = r_overrun | bit_valid;
                w_state_nxt   = c_idle;
            end
            default: begin
                w_state_nxt = c_idle;
            end
        endcase
    end

    assign shift_enable = (r_state == c_shift) && bit_valid;
    assign busy         = (r_state != c_idle);
    assign word_out     = r_word_out;
    assign word_valid   = r_word_valid;
    assign word_idx     = r_word_idx;
    assign word_last    = r_word_last;
    assign overrun      = r_overrun;
    assign len_err      = r_len_err;
    assign frame_done   = r_frame_done;

endmodule
`default_nettype wire

// File: tb/tb_stp_frame_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_stp_frame_ctrl
//  Description : Self-checking bench for stp_frame_ctrl with a behavioural
//                MSB-first shift register and a word-level reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_stp_frame_ctrl;

    localparam int NB = 8;
    localparam int MW = 16;
    localparam int LW = 5;
    localparam int IW = 4;

    logic          clk;
    logic          rst;
    logic          frame_start;
    logic [LW-1:0] frame_len;
    logic          bit_valid;
    logic          serial;
    logic [NB-1:0] sr;
    logic          shift_enable;
    logic [NB-1:0] word_out;
    logic          word_valid;
    logic          word_ready;
    logic [IW-1:0] word_idx;
    logic          word_last;
    logic          busy;
    logic          overrun;
    logic          len_err;
    logic          frame_done;

    int n_checks = 0;
    int n_errors = 0;

    stp_frame_ctrl #(.NUM_BITS(NB), .MAX_WORDS(MW)) dut (
        .clk          (clk),
        .rst          (rst),
        .frame_start  (frame_start),
        .frame_len    (frame_len),
        .bit_valid    (bit_valid),
        .parallel_in  (sr),
        .shift_enable (shift_enable),
        .word_out     (word_out),
        .word_valid   (word_valid),
        .word_ready   (word_ready),
        .word_idx     (word_idx),
        .word_last    (word_last),
        .busy         (busy),
        .overrun      (overrun),
        .len_err      (len_err),
        .frame_done   (frame_done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // MSB-first serial-to-parallel register standing in for flex_stp_sr.
    always @(posedge clk) begin
        if (rst) sr <= '1;
        else if (shift_enable) sr <= {sr[NB-2:0], serial};
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: frame progress as bits collected, words handed off.
    bit          m_init = 0;
    bit          m_active, m_fin, m_valid, m_last, m_ovr, m_lerr, m_done;
    int          m_nbits, m_words, m_len;
    logic [7:0]  m_acc, m_word;
    int          m_idx;

    always @(posedge clk) begin
        if (rst) begin
            m_init = 1; m_active = 0; m_fin = 0; m_valid = 0; m_last = 0;
            m_ovr = 0; m_lerr = 0; m_done = 0; m_nbits = 0; m_words = 0;
            m_len = 0; m_acc = 0; m_word = 0; m_idx = 0;
        end else if (m_init) begin
            m_lerr = 0;
            m_done = 0;
            if (!m_active) begin
                if (frame_start) begin
                    if (frame_len >= 1 && frame_len <= MW) begin
                        m_active = 1; m_len = int'(frame_len); m_nbits = 0;
                        m_words = 0; m_ovr = 0; m_acc = 0;
                    end else begin
                        m_lerr = 1;
                    end
                end
            end else if (m_fin) begin
                m_ovr = m_ovr | bit_valid;
                m_fin = 0;
                m_active = 0;
            end else if (m_nbits < NB) begin
                if (bit_valid) begin
                    m_acc = {m_acc[6:0], serial};
                    m_nbits++;
                end
            end else if (!m_valid) begin
                m_ovr = m_ovr | bit_valid;
                m_valid = 1; m_word = m_acc; m_idx = m_words;
                m_last = (m_words == m_len - 1);
            end else begin
                m_ovr = m_ovr | bit_valid;
                if (word_ready) begin
                    m_valid = 0;
                    if (m_last) begin
                        m_fin = 1; m_done = 1;
                    end else begin
                        m_words++; m_nbits = 0; m_acc = 0;
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        #2;
        if (m_init) begin
            chk("shift_enable", 32'(shift_enable), 32'(m_active && !m_fin && m_nbits < NB && bit_valid));
            chk("busy",         32'(busy),         32'(m_active));
            chk("word_valid",   32'(word_valid),   32'(m_valid));
            chk("word_out",     32'(word_out),     32'(m_word));
            chk("word_idx",     32'(word_idx),     32'(m_idx));
            chk("word_last",    32'(word_last),    32'(m_last));
            chk("overrun",      32'(overrun),      32'(m_ovr));
            chk("len_err",      32'(len_err),      32'(m_lerr));
            chk("frame_done",   32'(frame_done),   32'(m_done));
        end
    end

    task automatic start(input int len);
        @(negedge clk);
        frame_start = 1'b1;
        frame_len   = LW'(len);
        @(negedge clk);
        frame_start = 1'b0;
    endtask

    task automatic send_bits(input logic [7:0] b, input int n);
        for (int i = 7; i > 7 - n; i--) begin
            @(negedge clk);
            bit_valid = 1'b1;
            serial    = b[i];
        end
        @(negedge clk);
        bit_valid = 1'b0;
    endtask

    task automatic wait_valid(input string nm);
        int k;
        k = 0;
        while (!word_valid && k < 40) begin
            @(negedge clk);
            #1;
            k++;
        end
        if (!word_valid) chk({nm, "_timeout"}, 32'(word_valid), 32'd1);
    endtask

    task automatic wait_done(input string nm);
        int k;
        k = 0;
        while (!frame_done && k < 40) begin
            @(negedge clk);
            #1;
            k++;
        end
        chk(nm, 32'(frame_done), 32'd1);
    endtask

    initial begin
        rst = 1'b1; frame_start = 1'b0; frame_len = '0;
        bit_valid = 1'b1; serial = 1'b0; word_ready = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_shift_enable", 32'(shift_enable), 32'd0);
        chk("rst_word_valid", 32'(word_valid), 32'd0);
        chk("rst_word_out", 32'(word_out), 32'd0);
        rst = 1'b0; bit_valid = 1'b0;

        // Two-word frame, downstream always ready.
        word_ready = 1'b1;
        start(2);
        send_bits(8'h41, 8);
        wait_valid("w0");
        chk("lit_w0_data", 32'(word_out), 32'h41);
        chk("lit_w0_idx",  32'(word_idx), 32'd0);
        chk("lit_w0_last", 32'(word_last), 32'd0);
        send_bits(8'h42, 8);
        wait_valid("w1");
        chk("lit_w1_data", 32'(word_out), 32'h42);
        chk("lit_w1_idx",  32'(word_idx), 32'd1);
        chk("lit_w1_last", 32'(word_last), 32'd1);
        @(negedge clk); #1;
        chk("lit_done_pulse", 32'(frame_done), 32'd1);
        @(negedge clk); #1;
        chk("lit_idle_busy", 32'(busy), 32'd0);

        // Back-pressure with bits arriving while the word is held.
        word_ready = 1'b0;
        start(1);
        send_bits(8'hC3, 8);
        wait_valid("w2");
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            bit_valid = (c == 0 || c == 2);
            serial    = 1'b1;
        end
        @(negedge clk);
        bit_valid = 1'b0;
        #1;
        chk("lit_overrun_set", 32'(overrun), 32'd1);
        chk("lit_held_word", 32'(word_out), 32'hC3);
        word_ready = 1'b1;
        wait_done("lit_done_after_hold");
        repeat (2) @(negedge clk);
        #1;
        chk("lit_overrun_sticky", 32'(overrun), 32'd1);

        // Illegal lengths.
        start(0);
        #1;
        chk("lit_len_err_0", 32'(len_err), 32'd1);
        start(17);
        #1;
        chk("lit_len_err_17", 32'(len_err), 32'd1);
        chk("lit_len_err_busy", 32'(busy), 32'd0);
        @(negedge clk); #1;
        chk("lit_len_err_pulse_end", 32'(len_err), 32'd0);

        // Reset mid-word, then a fresh frame.
        start(1);
        send_bits(8'hE0, 3);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("lit_midrst_busy", 32'(busy), 32'd0);
        chk("lit_midrst_overrun", 32'(overrun), 32'd0);
        start(1);
        send_bits(8'h5A, 8);
        wait_valid("w3");
        chk("lit_w3_data", 32'(word_out), 32'h5A);
        chk("lit_w3_last", 32'(word_last), 32'd1);
        wait_done("lit_done_5a");

        // frame_start while a frame is running is ignored.
        start(2);
        @(negedge clk);
        frame_start = 1'b1;
        frame_len   = LW'(3);
        @(negedge clk);
        frame_start = 1'b0;
        send_bits(8'h11, 8);
        wait_valid("w4");
        send_bits(8'h22, 8);
        wait_valid("w5");
        chk("lit_w5_last", 32'(word_last), 32'd1);
        wait_done("lit_done_ignored_start");
        @(negedge clk); #1;
        chk("lit_final_busy", 32'(busy), 32'd0);

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

endmodule
`default_nettype wire
